// File: rtl/mux_arb_pkg.sv
// Shared types for the packet-level 2:1 arbiter: FSM states and requester IDs.
package mux_arb_pkg;

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/mux2_dp.sv
// Shared 2:1 select datapath: picks {last, data} of one requester by sel.
module mux2_dp #(
    parameter int WIDTH = 8
) (
    input  logic             sel_i,
    input  logic [WIDTH-1:0] dat0_i,
    input  logic             last0_i,
    input  logic [WIDTH-1:0] dat1_i,
    input  logic             last1_i,
    output logic [WIDTH-1:0] dat_o,
    output logic             last_o
);

    assign {last_o, dat_o} = sel_i ? {last1_i, dat1_i} : {last0_i, dat0_i};

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Packet-level round-robin arbiter: owns the mux select for a whole packet
// so beats of the two sources never interleave on the shared output stream.
module mux2_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] dat0,
    input  logic             last0,
    input  logic             req1,
    input  logic [WIDTH-1:0] dat1,
    input  logic             last1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             sel,
    output logic             busy
);

    arb_state_t       state_q, state_d;
    logic             prio_q, prio_d;
    logic             sel_q, sel_d;
    logic [WIDTH-1:0] dp_data;
    logic             dp_last;
    logic             xfer0, xfer1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            prio_q  <= REQ0;
            sel_q   <= REQ0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        out_valid = 1'b0;
        xfer0     = 1'b0;
        xfer1     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0 && req1) begin
                    state_d = (prio_q == REQ1) ? OWN1 : OWN0;
                end else if (req0) begin
                    state_d = OWN0;
                end else if (req1) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                out_valid = req0;
                xfer0     = req0 & out_ready;
                // Zero-bubble hand-over: the waiting requester owns the next cycle.
                if (xfer0 && last0) begin
                    prio_d  = REQ1;
                    state_d = req1 ? OWN1 : IDLE;
                end
            end
            OWN1: begin
                out_valid = req1;
                xfer1     = req1 & out_ready;
                if (xfer1 && last1) begin
                    prio_d  = REQ0;
                    state_d = req0 ? OWN0 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Select follows the owner; in IDLE it keeps pointing at the last owner.
    always_comb begin
        sel_d = sel_q;
        if (state_d == OWN0) begin
            sel_d = REQ0;
        end else if (state_d == OWN1) begin
            sel_d = REQ1;
        end
    end

    mux2_dp #(.WIDTH(WIDTH)) u_dp (
        .sel_i   (sel_q),
        .dat0_i  (dat0),
        .last0_i (last0),
        .dat1_i  (dat1),
        .last1_i (last1),
        .dat_o   (dp_data),
        .last_o  (dp_last)
    );

    assign busy     = (state_q != IDLE);
    assign sel      = sel_q;
    assign gnt0     = xfer0;
    assign gnt1     = xfer1;
    assign out_data = busy ? dp_data : '0;
    assign out_last = busy & dp_last;

endmodule
